// File: rtl/core_pkg.sv
// core_pkg: state encoding and instruction-memory constants shared by the boot sequencer.
package core_pkg;
    localparam int ADDR_W = 5;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_HALT} boot_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_count <= '0;
        else if (i_clr) r_count <= '0;
        else if (i_en && r_count != {W{1'b1}}) r_count <= r_count + 1'b1;
    end
    assign o_count = r_count;
endmodule

// File: rtl/boot_seq_ctrl.sv
// boot_seq_ctrl: loads LOAD_WORDS instructions into the I-cache, flushes, then runs the datapath until halt.
// Optional BOOT_CYCLE_LIMIT_EN also halts RUN once run_cycles reaches MAX_CYCLES.
module boot_seq_ctrl
    import core_pkg::*;
#(
    parameter int LOAD_WORDS = 32,
    parameter int MAX_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    output logic               in_ready,
    input  logic               halt_req,
    output logic               chip_enable,
    output logic [ADDR_W-1:0]  init_addr,
    output logic [INSTR_W-1:0] init_data,
    output logic               dp_reset,
    output logic               busy,
    output logic               done,
    output logic [15:0]        run_cycles
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_WORDS - 1);

    boot_state_t       r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              w_boot, w_accept, w_last, w_limit;

    if (LOAD_WORDS < 1 || LOAD_WORDS > 32) begin : g_bad_words
        $error("boot_seq_ctrl: LOAD_WORDS must be 1..32");
    end
    if (MAX_CYCLES < 1 || MAX_CYCLES > 65535) begin : g_bad_cycles
        $error("boot_seq_ctrl: MAX_CYCLES must be 1..65535");
    end

    assign w_boot   = start && (r_state == S_IDLE || r_state == S_HALT);
    assign w_accept = in_valid && r_state == S_LOAD;
    assign w_last   = r_addr == LAST_ADDR;
`ifdef BOOT_CYCLE_LIMIT_EN
    assign w_limit  = {16'd0, run_cycles} + 32'd1 >= 32'(MAX_CYCLES);
`else
    assign w_limit  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT: w_next = start ? S_LOAD : r_state;
            S_LOAD:         w_next = (w_accept && w_last) ? S_FLUSH : S_LOAD;
            S_FLUSH:        w_next = S_RUN;
            S_RUN:          w_next = (halt_req || w_limit) ? S_HALT : S_RUN;
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = r_state == S_LOAD;
        chip_enable = r_state == S_RUN;
        dp_reset    = r_state != S_RUN;
        busy        = r_state == S_LOAD || r_state == S_FLUSH || r_state == S_RUN;
        done        = r_state == S_HALT;
    end

    // address holds on the final word so it never wraps past LOAD_WORDS-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_addr <= '0;
        else if (w_boot) r_addr <= '0;
        else if (w_accept && !w_last) r_addr <= r_addr + 1'b1;
    end

    assign init_addr = r_addr;
    assign init_data = in_data;

    sat_counter #(.W(16)) u_run_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_boot),
        .i_en    (r_state == S_RUN),
        .o_count (run_cycles)
    );
endmodule

// File: tb/tb_boot_seq_ctrl.sv
// tb_boot_seq_ctrl: directed checks on a 32-word instance and a 4-word / MAX_CYCLES=5 instance.
module tb_boot_seq_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        a_start, a_in_valid, a_in_ready, a_halt, a_chip, a_dp_reset, a_busy, a_done;
    logic [31:0] a_in_data, a_init_data;
    logic [4:0]  a_init_addr;
    logic [15:0] a_run;
    logic        b_start, b_in_valid, b_in_ready, b_halt, b_chip, b_dp_reset, b_busy, b_done;
    logic [31:0] b_in_data, b_init_data;
    logic [4:0]  b_init_addr;
    logic [15:0] b_run;

    boot_seq_ctrl u_a (
        .clk(clk), .reset(reset), .start(a_start), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .halt_req(a_halt), .chip_enable(a_chip), .init_addr(a_init_addr),
        .init_data(a_init_data), .dp_reset(a_dp_reset), .busy(a_busy), .done(a_done), .run_cycles(a_run)
    );

    boot_seq_ctrl #(.LOAD_WORDS(4), .MAX_CYCLES(5)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .halt_req(b_halt), .chip_enable(b_chip), .init_addr(b_init_addr),
        .init_data(b_init_data), .dp_reset(b_dp_reset), .busy(b_busy), .done(b_done), .run_cycles(b_run)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int   exp_addr [7] = '{0, 1, 1, 1, 2, 3, 3};
        a_start = 0; a_in_valid = 0; a_in_data = 32'hDEAD_BEEF; a_halt = 0;
        b_start = 0; b_in_valid = 0; b_in_data = 32'h1234_5678; b_halt = 0;
        tick(2);
        check("rst_in_ready", a_in_ready, 0);
        check("rst_chip_en", a_chip, 0);
        check("rst_addr", a_init_addr, 0);
        check("rst_data", a_init_data, 32'hDEAD_BEEF);
        check("rst_dp_reset", a_dp_reset, 1);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_run", a_run, 0);
        reset = 0;
        a_start = 1;
        tick();
        a_start = 0;
        check("load_busy", a_busy, 1);
        check("load_in_ready", a_in_ready, 1);
        check("load_chip_en", a_chip, 0);
        check("load_dp_reset", a_dp_reset, 1);
        for (int i = 0; i < 32; i++) begin
            a_in_valid = 1;
            a_in_data = 32'hA000_0000 + i;
            #1;
            check("load_addr", a_init_addr, i);
            check("load_data", a_init_data, 32'hA000_0000 + i);
            tick();
        end
        a_in_valid = 0;
        check("flush_in_ready", a_in_ready, 0);
        check("flush_chip_en", a_chip, 0);
        check("flush_dp_reset", a_dp_reset, 1);
        check("flush_busy", a_busy, 1);
        check("flush_addr", a_init_addr, 31);
        tick();
        check("run_chip_en", a_chip, 1);
        check("run_dp_reset", a_dp_reset, 0);
        check("run_count0", a_run, 0);
        tick(3);
        a_start = 1;
        tick();
        a_start = 0;
        check("run_start_ign", a_chip, 1);
        check("run_count4", a_run, 4);
        tick(6);
        check("run_count10", a_run, 10);
        a_halt = 1;
        tick();
        a_halt = 0;
        check("halt_done", a_done, 1);
        check("halt_run", a_run, 11);
        check("halt_chip_en", a_chip, 0);
        check("halt_busy", a_busy, 0);
        tick(2);
        check("halt_hold_run", a_run, 11);
        check("halt_hold_done", a_done, 1);
        a_start = 1;
        tick();
        a_start = 0;
        check("reboot_in_ready", a_in_ready, 1);
        check("reboot_run", a_run, 0);
        check("reboot_addr", a_init_addr, 0);
        check("reboot_done", a_done, 0);
        a_in_valid = 1;
        tick(7);
        a_in_valid = 0;
        check("mid_addr7", a_init_addr, 7);
        #2;
        reset = 1;
        #1;
        check("async_busy", a_busy, 0);
        check("async_in_ready", a_in_ready, 0);
        check("async_addr", a_init_addr, 0);
        check("async_dp_reset", a_dp_reset, 1);
        tick();
        reset = 0;
        a_start = 1;
        tick();
        a_start = 0;
        check("restart_in_ready", a_in_ready, 1);
        check("restart_addr0", a_init_addr, 0);
        a_in_valid = 1;
        tick();
        a_in_valid = 0;
        check("restart_addr1", a_init_addr, 1);

        b_start = 1;
        tick();
        b_start = 0;
        for (int i = 0; i < 7; i++) begin
            b_in_valid = pat[i];
            b_in_data = 32'h0000_00B0 + i;
            #1;
            check("stall_addr", b_init_addr, exp_addr[i]);
            check("stall_in_ready", b_in_ready, 1);
            check("stall_data", b_init_data, 32'h0000_00B0 + i);
            tick();
        end
        b_in_valid = 0;
        check("b_flush_in_ready", b_in_ready, 0);
        check("b_flush_busy", b_busy, 1);
        check("b_flush_chip_en", b_chip, 0);
        check("b_flush_addr", b_init_addr, 3);
        tick();
        check("b_run_chip_en", b_chip, 1);
`ifdef BOOT_CYCLE_LIMIT_EN
        tick(4);
        check("limit_pre_done", b_done, 0);
        check("limit_pre_run", b_run, 4);
        tick();
        check("limit_done", b_done, 1);
        check("limit_run", b_run, 5);
        check("limit_chip_en", b_chip, 0);
`else
        tick(100);
        check("nolimit_chip_en", b_chip, 1);
        check("nolimit_done", b_done, 0);
        check("nolimit_run", b_run, 100);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/boot_seq_ctrl.md
BOOT_SEQ_CTRL -- requirements
Module: boot_seq_ctrl

Interface
REQ-001 SHALL have parameter LOAD_WORDS, default 32, meaning the number of instruction words loaded per boot (1..32).
REQ-002 SHALL have parameter MAX_CYCLES, default 1024, meaning the run-cycle limit (only used with BOOT_CYCLE_LIMIT_EN).
REQ-003 SHALL have port clk  input  1  meaning the single clock, rising-edge.
REQ-004 SHALL have port reset  input  1  meaning the reset; asynchronous, active-high.
REQ-005 SHALL have port start  input  1  meaning a boot request, sampled in IDLE and HALT.
REQ-006 SHALL have port in_valid  input  1  meaning in_data holds an instruction word.
REQ-007 SHALL have port in_data  input  32  meaning the instruction word to load.
REQ-008 SHALL have port in_ready  output  1  meaning the controller accepts in_data this cycle.
REQ-009 SHALL have port halt_req  input  1  meaning a datapath/host request to stop execution.
REQ-010 SHALL have port chip_enable  output  1  meaning 1 = datapath runs, 0 = cache init/NOP injection.
REQ-011 SHALL have port init_addr  output  5  meaning the instruction-cache write address.
REQ-012 SHALL have port init_data  output  32  meaning the instruction-cache write data.
REQ-013 SHALL have port dp_reset  output  1  meaning the synchronous reset held on the PC and register file.
REQ-014 SHALL have port busy  output  1  meaning the state is LOAD, FLUSH or RUN.
REQ-015 SHALL have port done  output  1  meaning the state is HALT.
REQ-016 SHALL have port run_cycles  output  16  meaning the count of RUN cycles in the current/last boot.

Function
REQ-017 SHALL implement states IDLE, LOAD, FLUSH, RUN and HALT, each state registered.
REQ-018 IDLE: start=1 SHALL move to LOAD, clearing the word counter, init_addr and run_cycles.
REQ-019 LOAD: in_ready=1, chip_enable=0, dp_reset=1, and each in_valid&in_ready cycle SHALL write the word.
REQ-020 Write rule: init_data=in_data combinationally, init_addr=word counter, and the counter SHALL increment after each accepted word.
REQ-021 In_valid low in LOAD SHALL stall with no write and no counter change, for any number of cycles.
REQ-022 Acceptance of word LOAD_WORDS-1 SHALL move to FLUSH on the next edge.
REQ-023 FLUSH: one cycle, chip_enable=0, dp_reset=1, in_ready=0; the next state SHALL be RUN.
REQ-024 RUN: chip_enable=1, dp_reset=0, in_ready=0, and run_cycles SHALL increment each cycle, saturating at 16'hFFFF.
REQ-025 RUN with halt_req=1 SHALL move to HALT on the next edge; the halt_req cycle counts in run_cycles.
REQ-026 HALT: chip_enable=0, done=1, run_cycles held; start=1 SHALL move to LOAD (re-boot), clearing as in REQ-018.
REQ-027 Start in LOAD/FLUSH/RUN SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-028 init_addr SHALL never exceed LOAD_WORDS-1, so there is no wrap.

Reset
REQ-029 Reset SHALL force IDLE immediately, independent of clk.
REQ-030 Reset values SHALL be: in_ready=0, chip_enable=0, init_addr=0, init_data=in_data, dp_reset=1, busy=0, done=0, run_cycles=0.
REQ-031 Reset mid-LOAD or mid-RUN SHALL abandon the boot; a new start SHALL reload from address 0.

Configuration
REQ-032 With BOOT_CYCLE_LIMIT_EN defined, RUN SHALL also move to HALT on the edge where run_cycles reaches MAX_CYCLES, with halt_req in the same cycle giving the same single transition.
REQ-033 Without BOOT_CYCLE_LIMIT_EN, RUN SHALL exit only via halt_req or reset, and MAX_CYCLES SHALL be unused.

Structure
REQ-034 The state enum, the ADDR_W=5 and INSTR_W=32 constants, and the NOP_INSTR constant SHALL live in the shared package core_pkg.
REQ-035 The run-cycle saturating counter SHALL be a sub-module named sat_counter; all other logic SHALL be flat.

Verification
REQ-036 Reset, start, then 32 words with continuous in_valid -> addresses 0..31 written, FLUSH 1 cycle, chip_enable=1 the following cycle.
REQ-037 LOAD_WORDS=4, in_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes at addresses 0..3, with no write on the low cycles.
REQ-038 RUN for 10 cycles, then halt_req=1 -> HALT, done=1, run_cycles=11, chip_enable=0.
REQ-039 With BOOT_CYCLE_LIMIT_EN and MAX_CYCLES=5, no halt_req -> HALT with run_cycles=5; without the macro -> still RUN after 100 cycles.
REQ-040 Reset asserted mid-LOAD after 7 words -> IDLE immediately; restart writes from address 0.
REQ-041 HALT, then start -> LOAD with run_cycles=0 and init_addr=0; start pulsed during RUN has no effect.
